// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32IM pipeline-stage registers.
//   pipe_state_e   : occupancy state of a pipeline stage (EMPTY / ONE / TWO)
//   *_DEF          : default field and counter widths
//   CTRL_*         : bit positions used when packing a stage's control field
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } pipe_state_e;

  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  // Control-field layout shared by ID/EX, EX/MEM and MEM/WB.
  localparam int CTRL_REG_WE    = 0;   // register-file write enable
  localparam int CTRL_MEM_RD    = 1;   // load
  localparam int CTRL_MEM_WR    = 2;   // store
  localparam int CTRL_ALU_SRC   = 3;   // 1 = immediate operand
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JUMP      = 5;
  localparam int CTRL_WB_SEL_LO = 6;   // 2-bit write-back mux select
  localparam int CTRL_ALU_OP_LO = 8;   // 5-bit ALU operation
  localparam int CTRL_MUL_DIV   = 13;  // M-extension unit select

endpackage

// File: rtl/pipe_sat_counter.sv
// Performance counter with synchronous clear and optional saturation.
//   CLK    : clock, rising edge
//   RESET  : synchronous, active-high; counter reads 0 afterwards
//   inc    : count this edge
//   clr    : clear this edge (wins over inc)
//   cnt    : current count
module pipe_sat_counter #(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation results that do not match the synthesised hardware.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (inc && (!SATURATE || cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register (control + data) with valid/ready handshake.
//   SKID=1 : main + skid entry, in_ready registered (no out_ready -> in_ready path)
//   SKID=0 : single entry, in_ready = out_ready | ~out_valid
// Ports:
//   CLK, RESET          : clock (rising) and synchronous active-high reset
//   flush               : drop held entries, discard this cycle's input, emit a bubble
//   in_valid/in_ready   : upstream handshake, in_ctrl/in_data carried with it
//   out_valid/out_ready : downstream handshake, out_ctrl/out_data presented with it
//   out_ctrl            : forced to 0 whenever out_valid=0 (bubble)
//   stall_cnt/cnt_clr   : saturating count of out_valid & ~out_ready edges, sync clear
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, take;
  logic              load_main, main_from_skid, load_skid;

  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && take) begin
          load_main = 1'b1;
        end else if (accept) begin
          // Downstream is stalled: park the new entry behind main.
          // Unreachable with SKID=0 because in_ready is then 0.
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // NOTE: the data registers are reset as well, because out_data must read 0
  // straight out of reset; this is what keeps them on the reset net.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        // Control is cleared so a flushed stage can never re-issue side
        // effects; data is left as-is since it is a don't-care in a bubble.
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_main) begin
          main_ctrl <= main_from_skid ? skid_ctrl : in_ctrl;
          main_data <= main_from_skid ? skid_data : in_data;
        end
        if (load_skid) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      // Registered ready: low only while both entries will be occupied.
      always_ff @(posedge CLK) begin
        if (RESET) in_ready_q <= 1'b1;
        else       in_ready_q <= (state_d != TWO);
      end
      assign in_ready = in_ready_q;
    end else begin : g_single
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  pipe_sat_counter #(
    .CNT_W    (CNT_W),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (out_valid & ~out_ready),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. Three builds share one set of inputs:
//   0: SKID=1, CNT_W=16   1: SKID=0, CNT_W=16   2: SKID=1, CNT_W=4
// The selected build is compared each cycle against an occupancy-queue model.
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int CW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          CLK = 1'b0;
  logic          RESET, flush, in_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [CW-1:0] ctl0, ctl1, ctl2;
  logic [DW-1:0] dat0, dat1, dat2;
  logic [15:0]   cnt0, cnt1;
  logic [3:0]    cnt2;

  int            sel;
  logic          o_ready, o_valid;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_data;
  logic [15:0]   o_cnt;

  ent_t q[$];
  int   m_cnt, m_max;
  bit   m_skid;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 CLK = ~CLK;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut_skid (
    .CLK(CLK), .RESET(RESET), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(vld0), .out_ready(out_ready),
    .out_ctrl(ctl0), .out_data(dat0), .stall_cnt(cnt0), .cnt_clr(cnt_clr));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut_single (
    .CLK(CLK), .RESET(RESET), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(vld1), .out_ready(out_ready),
    .out_ctrl(ctl1), .out_data(dat1), .stall_cnt(cnt1), .cnt_clr(cnt_clr));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut_cnt4 (
    .CLK(CLK), .RESET(RESET), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(vld2), .out_ready(out_ready),
    .out_ctrl(ctl2), .out_data(dat2), .stall_cnt(cnt2), .cnt_clr(cnt_clr));

  always_comb begin
    o_ready = rdy0; o_valid = vld0; o_ctrl = ctl0; o_data = dat0; o_cnt = cnt0;
    case (sel)
      1: begin o_ready = rdy1; o_valid = vld1; o_ctrl = ctl1; o_data = dat1; o_cnt = cnt1; end
      2: begin o_ready = rdy2; o_valid = vld2; o_ctrl = ctl2; o_data = dat2; o_cnt = 16'(cnt2); end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Registered ready is free whenever fewer than two entries are held;
  // single-register ready depends on this cycle's out_ready.
  function automatic bit exp_in_ready();
    if (m_skid) return q.size() < 2;
    return out_ready || q.size() == 0;
  endfunction

  task automatic check_outputs();
    check("out_valid", 128'(o_valid), 128'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 128'(o_data), 128'(q[0].d));
      check("out_ctrl", 128'(o_ctrl), 128'(q[0].c));
    end else begin
      check("bubble_ctrl", 128'(o_ctrl), 128'(0));
    end
    check("in_ready", 128'(o_ready), 128'(exp_in_ready()));
    check("stall_cnt", 128'(o_cnt), 128'(m_cnt));
  endtask

  task automatic model_edge();
    bit   ir;
    ent_t e;
    if (RESET) begin
      q.delete();
      m_cnt = 0;
    end else begin
      ir = exp_in_ready();
      if (cnt_clr) m_cnt = 0;
      else if (q.size() != 0 && !out_ready && m_cnt < m_max) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && ir) begin
          e.c = in_ctrl;
          e.d = in_data;
          q.push_back(e);
        end
      end
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge,
  // leave the caller #1 after the edge to drive the next inputs.
  task automatic tick();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit r, input logic [DW-1:0] d,
                       input bit f = 1'b0, input bit c = 1'b0);
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    in_ctrl   = d[CW-1:0] ^ 16'hA5A5;
    flush     = f;
    cnt_clr   = c;
  endtask

  task automatic do_reset(input int k);
    sel    = k;
    m_skid = (k != 1);
    m_max  = (k == 2) ? 15 : 65535;
    RESET  = 1'b1;
    drive(0, 0, '0);
    @(posedge CLK);
    model_edge();
    #1;
    tick();
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_data", 128'(o_data), 128'(0));
    check("rst_ready", 128'(o_ready), 128'(1));
    check("rst_cnt", 128'(o_cnt), 128'(0));
    RESET = 1'b0;
  endtask

  initial begin
    sel = 0;
    RESET = 1'b1;
    drive(0, 0, '0);
    q.delete();
    m_cnt = 0;

    // Reset, then streaming with out_ready held high.
    do_reset(0);
    for (int i = 1; i <= 6; i++) begin
      drive(1, 1, DW'(i));
      tick();
      check("stream_data", 128'(o_data), 128'(i));
      check("stream_ready", 128'(o_ready), 128'(1));
    end
    drive(0, 1, '0);
    tick();
    check("stream_cnt", 128'(o_cnt), 128'(0));

    // Skid fill: 0xA held in main, 0xB parked in skid.
    drive(1, 0, DW'('hA)); tick();
    drive(1, 0, DW'('hB)); tick();
    check("fill_ready", 128'(o_ready), 128'(0));
    check("fill_main", 128'(o_data), 128'('hA));
    drive(0, 0, '0); tick();
    check("fill_cnt", 128'(o_cnt), 128'(2));
    drive(0, 1, '0); tick();
    check("drain_b", 128'(o_data), 128'('hB));
    tick();
    check("drain_empty", 128'(o_valid), 128'(0));

    // Flush while full, with 0xC offered.
    drive(1, 0, DW'('hA)); tick();
    drive(1, 0, DW'('hB)); tick();
    drive(1, 0, DW'('hC), 1'b1); tick();
    check("flush_valid", 128'(o_valid), 128'(0));
    check("flush_ctrl", 128'(o_ctrl), 128'(0));
    check("flush_ready", 128'(o_ready), 128'(1));
    drive(0, 1, '0); tick(); tick();
    check("flush_no_c", 128'(o_valid), 128'(0));

    // Flush in ONE while in_ready=1: the offered entry is discarded.
    drive(1, 0, DW'('hA)); tick();
    drive(1, 1, DW'('hD), 1'b1); tick();
    check("flush1_valid", 128'(o_valid), 128'(0));
    drive(0, 1, '0); tick();
    check("flush1_no_d", 128'(o_valid), 128'(0));

    // Flush and RESET together: reset wins, counter cleared too.
    drive(1, 0, DW'('hA)); tick();
    drive(0, 0, '0); tick();
    RESET = 1'b1;
    drive(1, 0, DW'('hE), 1'b1); tick();
    RESET = 1'b0;
    check("rstfl_cnt", 128'(o_cnt), 128'(0));
    check("rstfl_valid", 128'(o_valid), 128'(0));
    check("rstfl_data", 128'(o_data), 128'(0));
    check("rstfl_ready", 128'(o_ready), 128'(1));

    // 4-bit counter saturation and clear.
    do_reset(2);
    drive(1, 0, DW'(5)); tick();
    drive(0, 0, '0);
    repeat (20) tick();
    check("cnt_sat", 128'(o_cnt), 128'(15));
    drive(0, 0, '0, 1'b0, 1'b1); tick();
    check("cnt_clr", 128'(o_cnt), 128'(0));
    drive(0, 0, '0); tick();
    check("cnt_again", 128'(o_cnt), 128'(1));

    // Single-register build: in_ready follows out_ready in the same cycle.
    do_reset(1);
    drive(1, 1, DW'(7)); tick();
    drive(0, 0, '0); #1;
    check("single_ready_lo", 128'(o_ready), 128'(0));
    drive(0, 1, '0); #1;
    check("single_ready_hi", 128'(o_ready), 128'(1));
    tick();

    // Random stress in both modes.
    for (int k = 0; k < 2; k++) begin
      do_reset(k);
      repeat (5000) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
              {$urandom, $urandom, $urandom},
              $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
